// File: rtl/foo_pkg.sv
// Shared definitions for the foo req/req_key/ack protocol (initiator, responder, bench).
package foo_pkg;

    localparam int unsigned KEY_W = 4;

    typedef logic [KEY_W-1:0] foo_key_t;

    // Value the responder's down-counter takes on reset.
    localparam foo_key_t RESP_RESET_KEY = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED,
        DONE
    } foo_init_state_t;

endpackage

// File: rtl/foo_key_mirror.sv
// Local copy of the responder's free-running 4-bit down-counter, with load.
module foo_key_mirror
    import foo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  logic     en_i,
    input  foo_key_t load_val_i,
    output foo_key_t key_nxt_o
);

    foo_key_t key_q;

    // The next value is exported so the initiator can register req_key in step with it.
    always_comb begin
        key_nxt_o = key_q;
        if (load_i) begin
            key_nxt_o = load_val_i;
        end else if (en_i) begin
            key_nxt_o = key_q - foo_key_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
        end else begin
            key_q <= key_nxt_o;
        end
    end

endmodule

// File: rtl/foo_initiator.sv
// Requester for the foo req/req_key/ack protocol: locks onto the responder's counter phase.
// Optional FOO_INIT_STATS_EN adds search_cycles and resync_count outputs.
module foo_initiator
    import foo_pkg::*;
#(
    parameter foo_key_t    PROBE_KEY      = 4'h0,
    parameter int unsigned SEARCH_TIMEOUT = 16,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned REQ_GAP        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_req,
    input  logic       ack,
    output logic       req,
    output foo_key_t   req_key,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] ack_count
`ifdef FOO_INIT_STATS_EN
   ,output logic [7:0] search_cycles,
    output logic [1:0] resync_count
`endif
);

    localparam int unsigned TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = (REQ_GAP > 0) ? $clog2(REQ_GAP + 1) : 1;

    foo_init_state_t state_q, state_d;
    logic [7:0]      num_q, num_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [RW-1:0]   retries_q, retries_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            error_q, error_d;
    logic            req_q, req_d;
    foo_key_t        key_q, key_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            acked;
    logic            retry_take;
    logic            mir_load;
    logic            mir_en;
    foo_key_t        mir_nxt;

    foo_key_mirror u_mirror (
        .clk        (clk),
        .rst        (rst),
        .load_i     (mir_load),
        .en_i       (mir_en),
        .load_val_i (PROBE_KEY - foo_key_t'(1)),
        .key_nxt_o  (mir_nxt)
    );

    // ack only counts against a request we actually drove this cycle.
    assign acked = req_q && ack;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        retries_d  = retries_q;
        gap_d      = gap_q;
        error_d    = error_q;
        retry_take = 1'b0;
        mir_load   = 1'b0;
        mir_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d     = num_req;
                    cnt_d     = '0;
                    retries_d = '0;
                    error_d   = 1'b0;
                    tmo_d     = '0;
                    state_d   = (num_req == '0) ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                tmo_d = tmo_q + TW'(1);
                if (acked) begin
                    mir_load = 1'b1;
                    cnt_d    = (cnt_q < num_q) ? cnt_q + 8'd1 : cnt_q;
                    gap_d    = GW'(REQ_GAP);
                    state_d  = (cnt_q + 8'd1 == num_q) ? DONE : LOCKED;
                end else if (tmo_q == TW'(SEARCH_TIMEOUT - 1)) begin
                    retry_take = 1'b1;
                end
            end
            LOCKED: begin
                mir_en = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (acked) begin
                    cnt_d   = (cnt_q < num_q) ? cnt_q + 8'd1 : cnt_q;
                    gap_d   = GW'(REQ_GAP);
                    state_d = (cnt_q + 8'd1 == num_q) ? DONE : LOCKED;
                end else if (req_q) begin
                    retry_take = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (retry_take) begin
            if (retries_q == RW'(MAX_RETRY)) begin
                error_d = 1'b1;
                state_d = DONE;
            end else begin
                retries_d = retries_q + RW'(1);
                tmo_d     = '0;
                state_d   = SEARCH;
            end
        end

        // Outputs are registered: derive next-cycle values from the next state.
        req_d  = (state_d == SEARCH) || ((state_d == LOCKED) && (gap_d == '0));
        key_d  = (state_d == SEARCH) ? PROBE_KEY :
                 (state_d == LOCKED) ? mir_nxt   : '0;
        busy_d = (state_d == SEARCH) || (state_d == LOCKED);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            retries_q <= '0;
            gap_q     <= '0;
            error_q   <= 1'b0;
            req_q     <= 1'b0;
            key_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            retries_q <= retries_d;
            gap_q     <= gap_d;
            error_q   <= error_d;
            req_q     <= req_d;
            key_q     <= key_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign req       = req_q;
    assign req_key   = key_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign ack_count = cnt_q;

`ifdef FOO_INIT_STATS_EN
    logic [7:0] search_q, search_d;

    always_comb begin
        search_d = search_q;
        if ((state_q == IDLE) && start) begin
            search_d = '0;
        end else if ((state_q == SEARCH) && (search_q != 8'hFF)) begin
            search_d = search_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            search_q <= '0;
        end else begin
            search_q <= search_d;
        end
    end

    assign search_cycles = search_q;
    assign resync_count  = 2'(retries_q);
`endif

endmodule

// File: tb/tb_foo_initiator.sv
// Directed bench for foo_initiator against a behavioural responder (free-running down-counter).
module tb_foo_initiator;
    import foo_pkg::*;

    logic       clk = 1'b0;
    logic       rst, rr0, rr1, ack_lo;
    logic       start0, start1;
    logic [7:0] num0, num1;

    logic       req0, busy0, done0, err0, ack0;
    logic       req1, busy1, done1, err1, ack1;
    foo_key_t   key0, key1, rc0, rc1;
    logic [7:0] cnt0, cnt1;
`ifdef FOO_INIT_STATS_EN
    logic [7:0] sc0, sc1;
    logic [1:0] rs0, rs1;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int dcyc;

    logic     lreq[0:127];
    logic     lack[0:127];
    foo_key_t lkey[0:127];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rc0 <= rr0 ? RESP_RESET_KEY : rc0 - 4'd1;
        rc1 <= rr1 ? RESP_RESET_KEY : rc1 - 4'd1;
    end

    assign ack0 = !ack_lo && req0 && (key0 == rc0);
    assign ack1 = req1 && (key1 == rc1);

    foo_initiator #(.MAX_RETRY(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .num_req(num0), .ack(ack0),
        .req(req0), .req_key(key0), .busy(busy0), .done(done0), .error(err0),
        .ack_count(cnt0)
`ifdef FOO_INIT_STATS_EN
       ,.search_cycles(sc0), .resync_count(rs0)
`endif
    );

    foo_initiator #(.REQ_GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .num_req(num1), .ack(ack1),
        .req(req1), .req_key(key1), .busy(busy1), .done(done1), .error(err1),
        .ack_count(cnt1)
`ifdef FOO_INIT_STATS_EN
       ,.search_cycles(sc1), .resync_count(rs1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_all();
        rst = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        step();
        step();
        rst = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        cyc = 0;
    endtask

    // Log req/key/ack per cycle until done rises; dc stays -1 if the budget expires.
    task automatic run(input bit sel, input int limit, output int dc);
        for (int i = 0; i < 128; i++) begin
            lreq[i] = 1'b0; lack[i] = 1'b0; lkey[i] = '0;
        end
        dc = -1;
        for (int n = 0; n < limit; n++) begin
            if (cyc < 128) begin
                lreq[cyc] = sel ? req1 : req0;
                lack[cyc] = sel ? ack1 : ack0;
                lkey[cyc] = sel ? key1 : key0;
            end
            if (sel ? done1 : done0) begin
                dc = cyc;
                break;
            end
            step();
        end
    endtask

    initial begin
        int first_ack;
        int req_seen;
        ack_lo = 1'b0;
        num0 = '0; num1 = '0;

        // Reset values, then basic lock and four acked requests.
        reset_all();
        check_eq("rst_req", req0, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_err", err0, 0);
        check_eq("rst_key", key0, 0);
        check_eq("rst_cnt", cnt0, 0);
        start0 = 1'b1; num0 = 8'd4;
        step();
        start0 = 1'b0;
        check_eq("t1_search_req", req0, 1);
        check_eq("t1_search_key", key0, 0);
        check_eq("t1_search_busy", busy0, 1);
        run(1'b0, 60, dcyc);
        first_ack = -1;
        for (int i = 0; i < 128; i++) begin
            if (lack[i] && first_ack < 0) first_ack = i;
        end
        check_eq("t1_first_ack", first_ack, 15);
        check_eq("t1_key16", lkey[16], 4'hF);
        check_eq("t1_key17", lkey[17], 4'hE);
        check_eq("t1_key18", lkey[18], 4'hD);
        check_eq("t1_acks16_18", {lack[16], lack[17], lack[18]}, 3'b111);
        check_eq("t1_done_cyc", dcyc, 19);
        check_eq("t1_cnt", cnt0, 4);
        check_eq("t1_err", err0, 0);
        step();
        check_eq("t1_done_pulse", done0, 0);
        check_eq("t1_busy_after", busy0, 0);

        // num_req == 0: done the cycle after start, no request.
        start0 = 1'b1; num0 = 8'd0; cyc = 0;
        step();
        start0 = 1'b0;
        run(1'b0, 10, dcyc);
        check_eq("t2_done_cyc", dcyc, 1);
        req_seen = 0;
        for (int i = 0; i < 4; i++) if (lreq[i]) req_seen++;
        step();
        if (req0) req_seen++;
        check_eq("t2_no_req", req_seen, 0);
        check_eq("t2_cnt", cnt0, 0);

        // REQ_GAP = 2: two idle cycles between locked requests.
        reset_all();
        start1 = 1'b1; num1 = 8'd3;
        step();
        start1 = 1'b0;
        run(1'b1, 60, dcyc);
        check_eq("t3_gap16_17", {lreq[16], lreq[17]}, 2'b00);
        check_eq("t3_req18", {lreq[18], lack[18]}, 2'b11);
        check_eq("t3_key18", lkey[18], 4'hD);
        check_eq("t3_gap19_20", {lreq[19], lreq[20]}, 2'b00);
        check_eq("t3_req21", {lreq[21], lack[21]}, 2'b11);
        check_eq("t3_key21", lkey[21], 4'hA);
        check_eq("t3_done_cyc", dcyc, 22);
        check_eq("t3_cnt", cnt1, 3);
        check_eq("t3_err", err1, 0);

        // Responder reset mid-LOCKED: sync lost, one re-search, then completes.
        reset_all();
        start0 = 1'b1; num0 = 8'd8;
        step();
        start0 = 1'b0;
        while (cyc < 17) step();
        rr0 = 1'b1;
        step();
        rr0 = 1'b0;
        check_eq("t4_lost_req", req0, 1);
        check_eq("t4_lost_key", key0, 4'hD);
        check_eq("t4_lost_ack", ack0, 0);
        step();
        check_eq("t4_research_key", {req0, key0}, 5'h10);
        run(1'b0, 60, dcyc);
        check_eq("t4_reacq", {lack[32], lack[33]}, 2'b01);
        check_eq("t4_done_cyc", dcyc, 38);
        check_eq("t4_cnt", cnt0, 8);
        check_eq("t4_err", err0, 0);
`ifdef FOO_INIT_STATS_EN
        check_eq("t4_resync", rs0, 1);
`endif

        // ack tied low: three 16-cycle searches then abort.
        reset_all();
        ack_lo = 1'b1;
        start0 = 1'b1; num0 = 8'd5;
        step();
        start0 = 1'b0;
        run(1'b0, 80, dcyc);
        check_eq("t5_done_cyc", dcyc, 49);
        check_eq("t5_err", err0, 1);
        check_eq("t5_cnt", cnt0, 0);
`ifdef FOO_INIT_STATS_EN
        check_eq("t5_search_cycles", sc0, 48);
        check_eq("t5_resync", rs0, 2);
`endif
        step();
        check_eq("t5_busy_after", busy0, 0);
        check_eq("t5_err_sticky", err0, 1);
        ack_lo = 1'b0;

        // Start clears error; rst mid-SEARCH drops the command silently.
        start0 = 1'b1; num0 = 8'd4;
        step();
        start0 = 1'b0;
        check_eq("t6_err_cleared", err0, 0);
        check_eq("t6_busy", busy0, 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_state", {req0, busy0, done0, key0}, 7'b0);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done0) req_seen++;
            step();
        end
        check_eq("t6_no_done", req_seen, 0);
        reset_all();
        start0 = 1'b1; num0 = 8'd2;
        step();
        start0 = 1'b0;
        run(1'b0, 60, dcyc);
        check_eq("t6_fresh_done_cyc", dcyc, 17);
        check_eq("t6_fresh_cnt", cnt0, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
